// File: rtl/move_controller.sv
`default_nettype none
// ============================================================================
// move_controller : cursor entry, legality check and disc flipping for one move
// Option: MOVE_CURSOR_WRAP_EN wraps cursor moves modulo 8 (default saturates).
// Revision: 1.0
// ============================================================================
module move_controller (
   input  logic       clock,
   input  logic       reset,
   input  logic       new_move,
   input  logic       player,
   input  logic       key_up,
   input  logic       key_down,
   input  logic       key_left,
   input  logic       key_right,
   input  logic       key_place,
   output logic [2:0] cursor_x,
   output logic [2:0] cursor_y,
   output logic [5:0] board_addr,
   input  logic [1:0] board_rdata,
   output logic       board_we,
   output logic [1:0] board_wdata,
   output logic       ack,
   output logic       invalid,
   output logic       busy
);

   localparam logic [2:0] c_IDLE   = 3'd0;
   localparam logic [2:0] c_CHECK  = 3'd1;
   localparam logic [2:0] c_SCAN   = 3'd2;
   localparam logic [2:0] c_FLIP   = 3'd3;
   localparam logic [2:0] c_PLACE  = 3'd4;
   localparam logic [2:0] c_ACK    = 3'd5;
   localparam logic [2:0] c_REJECT = 3'd6;

   // Direction steps as 4-bit two's complement; bit 3 of a position flags off-board.
   function automatic logic [3:0] f_dx(input logic [2:0] d);
      case (d)
         3'd1, 3'd2, 3'd3: f_dx = 4'd1;
         3'd5, 3'd6, 3'd7: f_dx = 4'hF;
         default:          f_dx = 4'd0;
      endcase
   endfunction

   function automatic logic [3:0] f_dy(input logic [2:0] d);
      case (d)
         3'd0, 3'd1, 3'd7: f_dy = 4'hF;
         3'd3, 3'd4, 3'd5: f_dy = 4'd1;
         default:          f_dy = 4'd0;
      endcase
   endfunction

   logic [2:0] r_state, w_next;
   logic [4:0] r_key_q;
   logic [2:0] r_cx, r_cy;
   logic [1:0] r_own;
   logic [3:0] r_px, r_py;
   logic [2:0] r_dir, r_cnt;
   logic       r_phase, r_flag;

   logic [4:0] w_keys, w_rise;
   logic [2:0] w_dir_n, w_cx_inc, w_cx_dec, w_cy_inc, w_cy_dec;
   logic [3:0] w_dx, w_dy, w_dx_n, w_dy_n;
   logic [1:0] w_opp;
   logic       w_off, w_flag_now, w_adv, w_step, w_flip_go, w_scan_go;

   assign w_keys     = {key_place, key_up, key_down, key_left, key_right};
   assign w_rise     = w_keys & ~r_key_q;
   assign w_dir_n    = r_dir + 3'd1;
   assign w_dx       = f_dx(r_dir);
   assign w_dy       = f_dy(r_dir);
   assign w_dx_n     = f_dx(w_dir_n);
   assign w_dy_n     = f_dy(w_dir_n);
   assign w_opp      = {r_own[0], r_own[1]};
   assign w_off      = r_px[3] | r_py[3];
   assign w_flag_now = r_flag | (r_state == c_FLIP);

`ifdef MOVE_CURSOR_WRAP_EN
   assign w_cx_inc = r_cx + 3'd1;
   assign w_cx_dec = r_cx - 3'd1;
   assign w_cy_inc = r_cy + 3'd1;
   assign w_cy_dec = r_cy - 3'd1;
`else
   assign w_cx_inc = (r_cx == 3'd7) ? r_cx : r_cx + 3'd1;
   assign w_cx_dec = (r_cx == 3'd0) ? r_cx : r_cx - 3'd1;
   assign w_cy_inc = (r_cy == 3'd7) ? r_cy : r_cy + 3'd1;
   assign w_cy_dec = (r_cy == 3'd0) ? r_cy : r_cy - 3'd1;
`endif

   always_ff @(posedge clock) begin
      if (!reset) r_state <= c_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      w_adv     = 1'b0;
      w_step    = 1'b0;
      w_flip_go = 1'b0;
      w_scan_go = 1'b0;
      case (r_state)
         c_IDLE:   if (new_move && w_rise[4]) w_next = c_CHECK;
         c_CHECK:  if (r_phase) begin
                      if (board_rdata != 2'b00) w_next = c_REJECT;
                      else begin
                         w_next    = c_SCAN;
                         w_scan_go = 1'b1;
                      end
                   end
         c_SCAN:   if (!r_phase) begin
                      if (w_off) w_adv = 1'b1;
                   end else if (board_rdata == w_opp) begin
                      w_step = 1'b1;
                   end else if (board_rdata == r_own && r_cnt != 3'd0) begin
                      w_next    = c_FLIP;
                      w_flip_go = 1'b1;
                   end else begin
                      w_adv = 1'b1;
                   end
         c_FLIP:   if (r_cnt == 3'd1) w_adv = 1'b1;
         c_PLACE:  w_next = c_ACK;
         c_ACK:    if (!key_place) w_next = c_IDLE;
         c_REJECT: w_next = c_IDLE;
         default:  w_next = c_IDLE;
      endcase
      if (w_adv) begin
         if (r_dir != 3'd7)   w_next = c_SCAN;
         else if (w_flag_now) w_next = c_PLACE;
         else                 w_next = c_REJECT;
      end
   end

   always_comb begin
      busy        = (r_state != c_IDLE);
      ack         = (r_state == c_ACK);
      invalid     = (r_state == c_REJECT);
      board_we    = (r_state == c_FLIP) || (r_state == c_PLACE);
      board_wdata = r_own;
      board_addr  = {r_cy, r_cx};
      if (r_state == c_SCAN || r_state == c_FLIP) board_addr = {r_py[2:0], r_px[2:0]};
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_key_q <= 5'd0;
         r_cx    <= 3'd0;
         r_cy    <= 3'd0;
         r_own   <= 2'b00;
         r_px    <= 4'd0;
         r_py    <= 4'd0;
         r_dir   <= 3'd0;
         r_cnt   <= 3'd0;
         r_phase <= 1'b0;
         r_flag  <= 1'b0;
      end else begin
         r_key_q <= w_keys;
         case (r_state)
            c_IDLE: if (new_move) begin
               if (w_rise[4]) begin
                  r_own   <= player ? 2'b10 : 2'b01;
                  r_phase <= 1'b0;
               end
               else if (w_rise[3]) r_cy <= w_cy_dec;
               else if (w_rise[2]) r_cy <= w_cy_inc;
               else if (w_rise[1]) r_cx <= w_cx_dec;
               else if (w_rise[0]) r_cx <= w_cx_inc;
            end
            c_CHECK: begin
               r_phase <= ~r_phase;
               if (w_scan_go) begin
                  r_dir   <= 3'd0;
                  r_flag  <= 1'b0;
                  r_cnt   <= 3'd0;
                  r_phase <= 1'b0;
                  r_px    <= {1'b0, r_cx} + f_dx(3'd0);
                  r_py    <= {1'b0, r_cy} + f_dy(3'd0);
               end
            end
            c_SCAN: begin
               if (!r_phase && !w_off) r_phase <= 1'b1;
               if (w_step) begin
                  r_px    <= r_px + w_dx;
                  r_py    <= r_py + w_dy;
                  r_cnt   <= r_cnt + 3'd1;
                  r_phase <= 1'b0;
               end
               // Rewind to the nearest captured cell so flips go outward.
               if (w_flip_go) begin
                  r_px <= {1'b0, r_cx} + w_dx;
                  r_py <= {1'b0, r_cy} + w_dy;
               end
            end
            c_FLIP: begin
               r_px   <= r_px + w_dx;
               r_py   <= r_py + w_dy;
               r_cnt  <= r_cnt - 3'd1;
               r_flag <= 1'b1;
            end
            default: ;
         endcase
         if (w_adv) begin
            r_dir   <= w_dir_n;
            r_cnt   <= 3'd0;
            r_phase <= 1'b0;
            r_px    <= {1'b0, r_cx} + w_dx_n;
            r_py    <= {1'b0, r_cy} + w_dy_n;
         end
      end
   end

   assign cursor_x = r_cx;
   assign cursor_y = r_cy;

endmodule
`default_nettype wire

// File: tb/tb_move_controller.sv
`default_nettype none
// Directed bench for move_controller with a behavioural 64-cell board memory.
module tb_move_controller;

   logic       clock, reset, new_move, player;
   logic       key_up, key_down, key_left, key_right, key_place;
   logic [2:0] cursor_x, cursor_y;
   logic [5:0] board_addr;
   logic [1:0] board_rdata, board_wdata;
   logic       board_we, ack, invalid, busy;

   logic [1:0] mem [64];
   logic [7:0] wr_q [$];
   int         n_vec, n_err, n_inv, n_ack;

   move_controller dut (
      .clock(clock), .reset(reset), .new_move(new_move), .player(player),
      .key_up(key_up), .key_down(key_down), .key_left(key_left),
      .key_right(key_right), .key_place(key_place),
      .cursor_x(cursor_x), .cursor_y(cursor_y), .board_addr(board_addr),
      .board_rdata(board_rdata), .board_we(board_we), .board_wdata(board_wdata),
      .ack(ack), .invalid(invalid), .busy(busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) board_rdata <= mem[board_addr];

   // One cycle; writes are logged and applied to the board image here.
   task automatic tick();
      @(posedge clock); #1;
      if (board_we) begin
         wr_q.push_back({board_addr, board_wdata});
         mem[board_addr] = board_wdata;
      end
      if (invalid) n_inv++;
      if (ack) n_ack++;
   endtask

   task automatic set_keys(input logic [4:0] v);
      {key_place, key_up, key_down, key_left, key_right} = v;
   endtask

   task automatic press(input logic [4:0] v);
      set_keys(v); tick(); set_keys(5'd0); tick();
   endtask

   task automatic clear_log();
      wr_q.delete(); n_inv = 0; n_ack = 0;
   endtask

   task automatic do_reset();
      reset = 1'b0; new_move = 1'b0; player = 1'b0; set_keys(5'd0);
      tick(); tick();
      reset = 1'b1;
      clear_log();
   endtask

   task automatic goto_xy(input int x, input int y);
      new_move = 1'b1;
      repeat (x) press(5'b00001);
      repeat (y) press(5'b00100);
   endtask

   task automatic start_board();
      for (int i = 0; i < 64; i++) mem[i] = 2'b00;
      mem[27] = 2'b10; mem[36] = 2'b10; mem[28] = 2'b01; mem[35] = 2'b01;
   endtask

   task automatic place_and_wait(output bit timeout);
      set_keys(5'b10000); tick(); set_keys(5'd0);
      timeout = 1'b1;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (!busy) begin timeout = 1'b0; break; end
      end
   endtask

   function automatic logic [7:0] wr_at(input int i);
      return (wr_q.size() > i) ? wr_q[i] : 8'hFF;
   endfunction

   task automatic test_reset();
      do_reset();
      n_vec++; if (cursor_x !== 3'd0)    begin n_err++; $display("FAIL reset_cursor_x: got %0d want 0", cursor_x); end
      n_vec++; if (cursor_y !== 3'd0)    begin n_err++; $display("FAIL reset_cursor_y: got %0d want 0", cursor_y); end
      n_vec++; if (busy !== 1'b0)        begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_vec++; if (ack !== 1'b0)         begin n_err++; $display("FAIL reset_ack: got %b want 0", ack); end
      n_vec++; if (invalid !== 1'b0)     begin n_err++; $display("FAIL reset_invalid: got %b want 0", invalid); end
      n_vec++; if (board_we !== 1'b0)    begin n_err++; $display("FAIL reset_we: got %b want 0", board_we); end
      n_vec++; if (board_addr !== 6'd0)  begin n_err++; $display("FAIL reset_addr: got %0d want 0", board_addr); end
      n_vec++; if (board_wdata !== 2'd0) begin n_err++; $display("FAIL reset_wdata: got %b want 00", board_wdata); end
   endtask

   task automatic test_cursor();
      do_reset();
      goto_xy(3, 2);
      n_vec++; if ({cursor_x, cursor_y} !== {3'd3, 3'd2}) begin n_err++; $display("FAIL cursor_move: got x%0d y%0d want x3 y2", cursor_x, cursor_y); end
      new_move = 1'b0; press(5'b00001);
      n_vec++; if (cursor_x !== 3'd3) begin n_err++; $display("FAIL cursor_no_new_move: got x%0d want x3", cursor_x); end
      new_move = 1'b1; press(5'b00111);
      n_vec++; if ({cursor_x, cursor_y} !== {3'd3, 3'd3}) begin n_err++; $display("FAIL cursor_prio_down: got x%0d y%0d want x3 y3", cursor_x, cursor_y); end
      press(5'b00011);
      n_vec++; if (cursor_x !== 3'd2) begin n_err++; $display("FAIL cursor_prio_left: got x%0d want x2", cursor_x); end
      set_keys(5'b00001); tick(); tick(); tick(); set_keys(5'd0); tick();
      n_vec++; if (cursor_x !== 3'd3) begin n_err++; $display("FAIL cursor_held_key: got x%0d want x3", cursor_x); end
   endtask

   task automatic test_boundary();
      logic [2:0] exp_x7r, exp_y0u, exp_l;
`ifdef MOVE_CURSOR_WRAP_EN
      exp_x7r = 3'd0; exp_y0u = 3'd7; exp_l = 3'd7;
`else
      exp_x7r = 3'd7; exp_y0u = 3'd0; exp_l = 3'd6;
`endif
      do_reset();
      goto_xy(7, 0);
      n_vec++; if (cursor_x !== 3'd7) begin n_err++; $display("FAIL edge_x7: got x%0d want x7", cursor_x); end
      press(5'b00001);
      n_vec++; if (cursor_x !== exp_x7r) begin n_err++; $display("FAIL edge_right_at_7: got x%0d want x%0d", cursor_x, exp_x7r); end
      press(5'b01000);
      n_vec++; if (cursor_y !== exp_y0u) begin n_err++; $display("FAIL edge_up_at_0: got y%0d want y%0d", cursor_y, exp_y0u); end
      press(5'b00010);
      n_vec++; if (cursor_x !== exp_l) begin n_err++; $display("FAIL edge_left: got x%0d want x%0d", cursor_x, exp_l); end
   endtask

   task automatic test_valid_move();
      bit to;
      do_reset(); start_board(); goto_xy(3, 2); clear_log();
      place_and_wait(to);
      n_vec++; if (to !== 1'b0)       begin n_err++; $display("FAIL valid_timeout: move did not finish"); end
      n_vec++; if (wr_q.size() != 2)  begin n_err++; $display("FAIL valid_nwrites: got %0d want 2", wr_q.size()); end
      n_vec++; if (wr_at(0) !== {6'd27, 2'b01}) begin n_err++; $display("FAIL valid_write0: got %h want %h", wr_at(0), {6'd27, 2'b01}); end
      n_vec++; if (wr_at(1) !== {6'd19, 2'b01}) begin n_err++; $display("FAIL valid_write1: got %h want %h", wr_at(1), {6'd19, 2'b01}); end
      n_vec++; if (n_ack != 1 || n_inv != 0) begin n_err++; $display("FAIL valid_ack: got ack %0d inv %0d want 1 0", n_ack, n_inv); end
   endtask

   task automatic test_no_capture();
      bit to;
      do_reset(); start_board(); new_move = 1'b1; clear_log();
      place_and_wait(to);
      n_vec++; if (to !== 1'b0)      begin n_err++; $display("FAIL nocap_timeout: move did not finish"); end
      n_vec++; if (n_inv != 1)       begin n_err++; $display("FAIL nocap_invalid: got %0d cycles want 1", n_inv); end
      n_vec++; if (wr_q.size() != 0) begin n_err++; $display("FAIL nocap_writes: got %0d want 0", wr_q.size()); end
      n_vec++; if (n_ack != 0)       begin n_err++; $display("FAIL nocap_ack: got %0d want 0", n_ack); end
   endtask

   task automatic test_occupied();
      int bad; bit to;
      do_reset(); start_board(); goto_xy(3, 3); clear_log();
      set_keys(5'b10000); tick(); set_keys(5'd0);
      bad = 0; to = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (!busy) begin to = 1'b0; break; end
         if (board_addr !== 6'd27) bad++;
         tick();
      end
      n_vec++; if (to !== 1'b0 || bad != 0) begin n_err++; $display("FAIL occ_reads: got %0d off-cursor cycles timeout %b want 0 0", bad, to); end
      n_vec++; if (n_inv != 1 || wr_q.size() != 0) begin n_err++; $display("FAIL occ_reject: got inv %0d writes %0d want 1 0", n_inv, wr_q.size()); end
   endtask

   task automatic test_multi_capture();
      bit to;
      do_reset();
      for (int i = 0; i < 64; i++) mem[i] = 2'b00;
      mem[9] = 2'b10; mem[18] = 2'b10; mem[27] = 2'b01;
      new_move = 1'b1; clear_log();
      place_and_wait(to);
      n_vec++; if (to !== 1'b0 || wr_q.size() != 3) begin n_err++; $display("FAIL multi_nwrites: got %0d timeout %b want 3 0", wr_q.size(), to); end
      n_vec++; if ({wr_at(0), wr_at(1), wr_at(2)} !== {6'd9, 2'b01, 6'd18, 2'b01, 6'd0, 2'b01})
         begin n_err++; $display("FAIL multi_order: got %h %h %h want 25 49 01", wr_at(0), wr_at(1), wr_at(2)); end
   endtask

   task automatic test_white_atomic();
      bit to;
      do_reset(); start_board(); goto_xy(4, 2); player = 1'b1; clear_log();
      set_keys(5'b10000); tick(); set_keys(5'd0);
      new_move = 1'b0; player = 1'b0;
      to = 1'b1;
      for (int i = 0; i < 300; i++) begin tick(); if (!busy) begin to = 1'b0; break; end end
      n_vec++; if (to !== 1'b0 || wr_q.size() != 2) begin n_err++; $display("FAIL white_nwrites: got %0d timeout %b want 2 0", wr_q.size(), to); end
      n_vec++; if ({wr_at(0), wr_at(1)} !== {6'd28, 2'b10, 6'd20, 2'b10}) begin n_err++; $display("FAIL white_writes: got %h %h want 72 52", wr_at(0), wr_at(1)); end
      n_vec++; if (n_ack != 1) begin n_err++; $display("FAIL white_ack: got %0d want 1", n_ack); end
   endtask

   task automatic test_hold_place();
      int bad; bit got;
      do_reset(); start_board(); goto_xy(3, 2); clear_log();
      set_keys(5'b10000); got = 1'b0;
      for (int i = 0; i < 300; i++) begin tick(); if (ack) begin got = 1'b1; break; end end
      n_vec++; if (got !== 1'b1) begin n_err++; $display("FAIL hold_ack_seen: got %b want 1", got); end
      bad = 0;
      repeat (10) begin tick(); if (ack !== 1'b1 || busy !== 1'b1) bad++; end
      n_vec++; if (bad != 0) begin n_err++; $display("FAIL hold_ack_stays: got %0d drops want 0", bad); end
      set_keys(5'd0); tick();
      n_vec++; if (ack !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL hold_release: got ack %b busy %b want 0 0", ack, busy); end
      bad = 0;
      repeat (20) begin tick(); if (busy) bad++; end
      n_vec++; if (bad != 0 || wr_q.size() != 2) begin n_err++; $display("FAIL hold_second_move: got busy %0d writes %0d want 0 2", bad, wr_q.size()); end
   endtask

   task automatic test_flip_reset();
      bit got;
      do_reset(); start_board(); goto_xy(3, 2); clear_log();
      set_keys(5'b10000); tick(); set_keys(5'd0);
      got = 1'b0;
      for (int i = 0; i < 300; i++) begin if (board_we) begin got = 1'b1; break; end tick(); end
      n_vec++; if (got !== 1'b1) begin n_err++; $display("FAIL flipreset_no_flip: got %b want 1", got); end
      reset = 1'b0; tick();
      n_vec++; if ({board_we, busy, ack} !== 3'b000) begin n_err++; $display("FAIL flipreset_ctrl: got we%b busy%b ack%b want 000", board_we, busy, ack); end
      n_vec++; if ({cursor_x, cursor_y} !== 6'd0) begin n_err++; $display("FAIL flipreset_cursor: got x%0d y%0d want x0 y0", cursor_x, cursor_y); end
      reset = 1'b1; tick();
   endtask

   initial begin
      n_vec = 0; n_err = 0; n_inv = 0; n_ack = 0;
      reset = 1'b0; new_move = 1'b0; player = 1'b0; set_keys(5'd0);
      for (int i = 0; i < 64; i++) mem[i] = 2'b00;
      test_reset();
      test_cursor();
      test_boundary();
      test_valid_move();
      test_no_capture();
      test_occupied();
      test_multi_capture();
      test_white_atomic();
      test_hold_place();
      test_flip_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
